// File: rtl/reg_writeback_pkg.sv
`default_nettype none
// ============================================================================
// reg_writeback_pkg : shared encodings, FSM state type and defaults
// Rev 1.0
// ============================================================================
package reg_writeback_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREGS = 8;

    localparam logic [2:0] SRC_NONE = 3'b000;
    localparam logic [2:0] SRC_ALU  = 3'b001;
    localparam logic [2:0] SRC_MEM  = 3'b010;
    localparam logic [2:0] SRC_IMM  = 3'b011;
    localparam logic [2:0] SRC_PAR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } wb_state_t;

    // Selects above SRC_PAR fall back to no-write, like the upstream mux default.
    function automatic logic sel_writes(input logic [2:0] sel);
        return (sel != SRC_NONE) && (sel <= SRC_PAR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_core.sv
`default_nettype none
// ============================================================================
// reg_file_core : register array, 1 write port, 2 async read ports, r0 = 0
// Rev 1.0
// ============================================================================
module reg_file_core #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : r_mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : r_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// reg_writeback : write-back FSM, pipeline register, read forwarding, flags
// Rev 1.0
// ============================================================================
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREGS = DEFAULT_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wb_valid,
    input  logic [2:0]       wb_sel,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [AW-1:0]    wb_addr,
    input  logic             mem_ready,
    output logic             wb_stall,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             flag_zero,
    output logic             flag_parity
);

    wb_state_t        r_state;
    wb_state_t        w_next_state;
    logic [AW-1:0]    r_pipe_addr;
    logic [WIDTH-1:0] r_pipe_data;
    logic             r_flag_zero;
    logic             r_flag_parity;

    logic             w_req_write;
    logic             w_req_wait;
    logic             w_latch;
    logic             w_stall;
    logic             w_commit;
    logic             w_we;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic [WIDTH-1:0] w_file_a;
    logic [WIDTH-1:0] w_file_b;

    always_comb begin
        w_req_write  = wb_valid && sel_writes(wb_sel) && ((wb_sel != SRC_MEM) || mem_ready);
        w_req_wait   = wb_valid && (wb_sel == SRC_MEM) && !mem_ready;
        w_latch      = 1'b0;
        w_stall      = 1'b0;
        w_next_state = ST_IDLE;
        case (r_state)
            ST_WAIT_MEM: begin
                w_stall      = !mem_ready;
                w_latch      = mem_ready;
                w_next_state = mem_ready ? ST_COMMIT : ST_WAIT_MEM;
            end
            // IDLE and COMMIT take new requests identically; COMMIT drains in parallel.
            default: begin
                w_stall = w_req_wait;
                w_latch = w_req_write;
                if (w_req_write) begin
                    w_next_state = ST_COMMIT;
                end else if (w_req_wait) begin
                    w_next_state = ST_WAIT_MEM;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_pipe_addr   <= '0;
            r_pipe_data   <= '0;
            r_flag_zero   <= 1'b0;
            r_flag_parity <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_pipe_addr <= wb_addr;
                r_pipe_data <= wb_data;
            end
            if (w_commit) begin
                r_flag_zero   <= (r_pipe_data == '0);
                r_flag_parity <= ^r_pipe_data;
            end
        end
    end

    assign w_commit = (r_state == ST_COMMIT);
    assign w_we     = w_commit && (r_pipe_addr != '0);

    reg_file_core #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (w_we),
        .waddr   (r_pipe_addr),
        .wdata   (r_pipe_data),
        .raddr_a (ra_addr),
        .rdata_a (w_file_a),
        .raddr_b (rb_addr),
        .rdata_b (w_file_b)
    );

    assign w_fwd_a = w_we && (ra_addr == r_pipe_addr);
    assign w_fwd_b = w_we && (rb_addr == r_pipe_addr);

    assign ra_data     = w_fwd_a ? r_pipe_data : w_file_a;
    assign rb_data     = w_fwd_b ? r_pipe_data : w_file_b;
    assign wb_stall    = reset_n && w_stall;
    assign flag_zero   = r_flag_zero;
    assign flag_parity = r_flag_parity;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// tb_reg_writeback : directed scoreboard bench for reg_writeback
// Rev 1.0
// ============================================================================
module tb_reg_writeback;

    localparam int WIDTH = 8;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             wb_valid;
    logic [2:0]       wb_sel;
    logic [WIDTH-1:0] wb_data;
    logic [AW-1:0]    wb_addr;
    logic             mem_ready;
    logic             wb_stall;
    logic [AW-1:0]    ra_addr;
    logic [AW-1:0]    rb_addr;
    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic             flag_zero;
    logic             flag_parity;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wb_exp_t;

    wb_exp_t          sb[$];
    logic [WIDTH-1:0] model [NREGS];
    logic             exp_zero;
    logic             exp_parity;
    int               checks   = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    reg_writeback #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wb_valid    (wb_valid),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .wb_addr     (wb_addr),
        .mem_ready   (mem_ready),
        .wb_stall    (wb_stall),
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .ra_data     (ra_data),
        .rb_data     (rb_data),
        .flag_zero   (flag_zero),
        .flag_parity (flag_parity)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d, input logic mr);
        wb_valid  = v;
        wb_sel    = s;
        wb_addr   = a;
        wb_data   = d;
        mem_ready = mr;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, '0, '0, 1'b0);
    endtask

    // Present a request with memory ready, expect no stall, record expected write.
    task automatic accept(input string tag, input logic [2:0] s, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d);
        drive(1'b1, s, a, d, 1'b1);
        #1;
        chk({tag, " stall"}, wb_stall, 1'b0);
        if ((s != 3'b000) && (s <= 3'b100)) sb.push_back(wb_exp_t'{addr: a, data: d});
        cyc();
    endtask

    // Called in the COMMIT cycle: pop the oldest write and check the forwarded read.
    task automatic see_commit(input string tag, input bit port_b);
        wb_exp_t          e;
        logic [WIDTH-1:0] fwd;
        chk({tag, " sb_depth"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            fwd = (e.addr == '0) ? '0 : e.data;
            if (port_b) begin
                rb_addr = e.addr;
                #1;
                chk({tag, " fwd_b"}, rb_data, fwd);
            end else begin
                ra_addr = e.addr;
                #1;
                chk({tag, " fwd_a"}, ra_data, fwd);
            end
            if (e.addr != '0) model[e.addr] = e.data;
            exp_zero   = (e.data == '0);
            exp_parity = ^e.data;
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, " flag_zero"}, flag_zero, exp_zero);
        chk({tag, " flag_parity"}, flag_parity, exp_parity);
    endtask

    task automatic chk_reg(input string tag, input logic [AW-1:0] a);
        ra_addr = a;
        #1;
        chk(tag, ra_data, model[a]);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        ra_addr = 3'd3;
        rb_addr = 3'd5;
        exp_zero   = 1'b0;
        exp_parity = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        #2;
        chk("reset stall", wb_stall, 1'b0);
        chk("reset flag_zero", flag_zero, 1'b0);
        chk("reset flag_parity", flag_parity, 1'b0);
        chk("reset ra", ra_data, 8'h00);
        chk("reset rb", rb_data, 8'h00);
        cyc();
        reset_n = 1'b1;

        // ALU write with forwarding in COMMIT
        ra_addr = 3'd3;
        accept("alu", 3'b001, 3'd3, 8'hA5);
        idle();
        see_commit("alu", 1'b0);
        cyc();
        chk_reg("alu r3", 3'd3);
        chk_flags("alu");

        // Back-to-back to r2, read through port B
        accept("b2b11", 3'b001, 3'd2, 8'h11);
        see_commit("b2b11", 1'b1);
        accept("b2b22", 3'b011, 3'd2, 8'h22);
        idle();
        see_commit("b2b22", 1'b1);
        cyc();
        rb_addr = 3'd2;
        #1;
        chk("b2b r2 stored", rb_data, model[2]);
        chk_flags("b2b");

        // Memory source stalled three cycles
        drive(1'b1, 3'b010, 3'd5, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mem stall", wb_stall, 1'b1);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("mem ready stall", wb_stall, 1'b0);
        sb.push_back(wb_exp_t'{addr: 3'd5, data: 8'h3C});
        chk_reg("mem r5 before", 3'd5);
        cyc();
        idle();
        see_commit("mem", 1'b0);
        cyc();
        chk_reg("mem r5", 3'd5);
        chk_flags("mem");

        // r0 write is dropped but flags still update
        accept("r0", 3'b001, 3'd0, 8'hFF);
        idle();
        see_commit("r0", 1'b0);
        cyc();
        chk_reg("r0 read", 3'd0);
        chk_flags("r0");

        // No-write selects leave r4 untouched
        accept("r4", 3'b100, 3'd4, 8'h5A);
        idle();
        see_commit("r4", 1'b0);
        cyc();
        chk_reg("r4 set", 3'd4);
        drive(1'b1, 3'b000, 3'd4, 8'h77, 1'b1);
        #1;
        chk("sel000 stall", wb_stall, 1'b0);
        cyc();
        drive(1'b1, 3'b111, 3'd4, 8'h77, 1'b1);
        #1;
        chk("sel111 stall", wb_stall, 1'b0);
        cyc();
        idle();
        cyc();
        chk_reg("r4 unchanged", 3'd4);
        chk_flags("nowrite");

        // Zero and parity flags
        accept("zero", 3'b011, 3'd1, 8'h00);
        idle();
        see_commit("zero", 1'b0);
        cyc();
        chk_flags("zero");
        accept("one", 3'b011, 3'd1, 8'h01);
        idle();
        see_commit("one", 1'b0);
        cyc();
        chk_flags("one");
        chk_reg("r1", 3'd1);

        // Reset during COMMIT of r6 discards the write
        drive(1'b1, 3'b001, 3'd6, 8'h99, 1'b1);
        #1;
        chk("rst req stall", wb_stall, 1'b0);
        cyc();
        idle();
        reset_n = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        sb.delete();
        exp_zero   = 1'b0;
        exp_parity = 1'b0;
        #1;
        chk_flags("in reset");
        chk_reg("in reset r6", 3'd6);
        chk_reg("in reset r3", 3'd3);
        cyc();
        reset_n = 1'b1;
        chk_reg("post reset r6", 3'd6);
        chk_flags("post reset");

        // First edge after release accepts normally
        accept("after rst", 3'b001, 3'd7, 8'hC3);
        idle();
        see_commit("after rst", 1'b0);
        cyc();
        chk_reg("after rst r7", 3'd7);
        chk_flags("after rst");

        for (int i = 0; i < NREGS; i++) chk_reg("sweep", i[AW-1:0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
